// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR4 test sequencer read path.
// exp_word is the single definition of the test pattern used by both write and read sides.
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } rd_state_e;

    localparam int BYTES_PER_BEAT = 64;
    localparam int BOUNDARY_4K    = 4096;

    function automatic logic [31:0] exp_word(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * 32'(BYTES_PER_BEAT);
    endfunction

endpackage

// File: rtl/ddr_rd_beat_cmp.sv
// Compares every 32-bit lane of an accepted R beat against the expected pattern word and
// reports a registered mismatch strobe together with the address of the offending beat.
module ddr_rd_beat_cmp #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [31:0]       exp_i,
    input  logic [ADDR_W-1:0] beat_addr_i,
    input  logic              accept_i,
    output logic              mism_o,
    output logic [ADDR_W-1:0] mism_addr_o
);

    localparam int LANES = DATA_W / 32;

    logic              any_bad;
    logic              mism_q;
    logic [ADDR_W-1:0] mism_addr_q;

    always_comb begin
        any_bad = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (rdata_i[l*32 +: 32] != exp_i) begin
                any_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mism_q      <= 1'b0;
            mism_addr_q <= '0;
        end else begin
            mism_q <= accept_i && any_bad;
            if (accept_i) begin
                mism_addr_q <= beat_addr_i;
            end
        end
    end

    assign mism_o      = mism_q;
    assign mism_addr_o = mism_addr_q;

endmodule

// File: rtl/ddr_rd_checker.sv
// AXI4 read engine: one AR burst per sequencer command, beat-by-beat pattern and protocol
// checking, and a one-cycle rd_finish so the sequencer can advance to its next command.
module ddr_rd_checker #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_burst_length,
    output logic              rd_finish,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [ID_W-1:0]   arid,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [ID_W-1:0]   rid,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    input  logic              clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              data_err,
    output logic              prot_err,
    output logic              bnd_err,
    output logic              len_err,
    output logic [ADDR_W-1:0] first_err_addr
);

    import ddr_rd_pkg::*;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_idx_q;
    logic [ID_W-1:0]   cmd_id_q;
    logic [CNT_W-1:0]  err_cnt_q, beat_cnt_q;
    logic              data_err_q, prot_err_q, bnd_err_q, len_err_q;
    logic [ADDR_W-1:0] first_err_addr_q;

    logic              latch, accept, is_last;
    logic [7:0]        eff_len;
    logic [15:0]       bnd_span;
    logic [ADDR_W-1:0] beat_addr;
    logic              mism;
    logic [ADDR_W-1:0] mism_addr;

    // A zero-length command still runs as a single beat so the sequencer never stalls.
    assign eff_len   = (rd_burst_length == 8'd0) ? 8'd1 : rd_burst_length;
    assign bnd_span  = 16'(rd_addr[11:0]) + 16'(eff_len) * 16'(BYTES_PER_BEAT);
    assign latch     = (state_q == IDLE) && rd_en;
    assign is_last   = (beat_idx_q == len_q - 8'd1);
    assign beat_addr = addr_q + ADDR_W'(beat_idx_q) * ADDR_W'(BYTES_PER_BEAT);

    always_comb begin
        state_d   = state_q;
        arvalid   = 1'b0;
        araddr    = '0;
        arlen     = 8'd0;
        arid      = '0;
        rready    = 1'b0;
        rd_finish = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_en) state_d = ADDR;
            end
            ADDR: begin
                arvalid = 1'b1;
                araddr  = addr_q;
                arlen   = len_q - 8'd1;
                arid    = cmd_id_q;
                if (arready) state_d = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    accept = 1'b1;
                    if (is_last) state_d = DONE;
                end
            end
            DONE: begin
                rd_finish = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= 8'd0;
            beat_idx_q <= 8'd0;
            cmd_id_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                addr_q <= rd_addr;
                len_q  <= eff_len;
            end
            if (arvalid && arready) begin
                beat_idx_q <= 8'd0;
            end else if (accept) begin
                beat_idx_q <= beat_idx_q + 8'd1;
            end
            if (state_q == DONE) begin
                cmd_id_q <= cmd_id_q + 1'b1;
            end
        end
    end

    ddr_rd_beat_cmp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_cmp (
        .clk         (clk),
        .reset       (reset),
        .rdata_i     (rdata),
        .exp_i       (exp_word(32'(addr_q), 32'(beat_idx_q))),
        .beat_addr_i (beat_addr),
        .accept_i    (accept),
        .mism_o      (mism),
        .mism_addr_o (mism_addr)
    );

    // Counters saturate; clr wins over anything arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q        <= '0;
            beat_cnt_q       <= '0;
            data_err_q       <= 1'b0;
            prot_err_q       <= 1'b0;
            bnd_err_q        <= 1'b0;
            len_err_q        <= 1'b0;
            first_err_addr_q <= '0;
        end else if (clr) begin
            err_cnt_q        <= '0;
            beat_cnt_q       <= '0;
            data_err_q       <= 1'b0;
            prot_err_q       <= 1'b0;
            bnd_err_q        <= 1'b0;
            len_err_q        <= 1'b0;
            first_err_addr_q <= '0;
        end else begin
            if (accept && (beat_cnt_q != '1)) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (mism) begin
                data_err_q <= 1'b1;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                if (!data_err_q) first_err_addr_q <= mism_addr;
            end
            if (accept && ((rresp != 2'd0) || (rid != cmd_id_q) || (rlast != is_last))) begin
                prot_err_q <= 1'b1;
            end
            if (latch && (rd_burst_length == 8'd0)) begin
                len_err_q <= 1'b1;
            end
            if (latch && (bnd_span > 16'(BOUNDARY_4K))) begin
                bnd_err_q <= 1'b1;
            end
        end
    end

    assign err_cnt        = err_cnt_q;
    assign beat_cnt       = beat_cnt_q;
    assign data_err       = data_err_q;
    assign prot_err       = prot_err_q;
    assign bnd_err        = bnd_err_q;
    assign len_err        = len_err_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Randomized scoreboard bench for ddr_rd_checker: expected AR beats are queued by the
// stimulus and popped by an independent monitor; status is compared against a pattern model.
module tb_ddr_rd_checker;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_en;
    logic [31:0]  rd_addr;
    logic [7:0]   rd_burst_length;
    logic         rd_finish;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [3:0]   arid;
    logic         arvalid;
    logic         arready;
    logic [511:0] rdata;
    logic [3:0]   rid;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         clr;
    logic [31:0]  err_cnt;
    logic [31:0]  beat_cnt;
    logic         data_err;
    logic         prot_err;
    logic         bnd_err;
    logic         len_err;
    logic [31:0]  first_err_addr;

    ddr_rd_checker #(
        .DATA_W(512),
        .ADDR_W(32),
        .ID_W  (4),
        .CNT_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_burst_length(rd_burst_length),
        .rd_finish      (rd_finish),
        .araddr         (araddr),
        .arlen          (arlen),
        .arid           (arid),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rid            (rid),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready),
        .clr            (clr),
        .err_cnt        (err_cnt),
        .beat_cnt       (beat_cnt),
        .data_err       (data_err),
        .prot_err       (prot_err),
        .bnd_err        (bnd_err),
        .len_err        (len_err),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } ar_exp_t;

    ar_exp_t     arQ[$];
    int          checks = 0;
    int          failures = 0;
    int          finishCount = 0;
    int          expFinish = 0;
    int          mBeatCnt, mErrCnt, mExpId;
    bit          mDataErr, mProtErr, mBndErr, mLenErr;
    logic [31:0] mFirstErr;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        mBeatCnt  = 0;
        mErrCnt   = 0;
        mDataErr  = 0;
        mProtErr  = 0;
        mBndErr   = 0;
        mLenErr   = 0;
        mFirstErr = 32'h0;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, " beat_cnt"}, 64'(beat_cnt), 64'(mBeatCnt));
        checkOutput({tag, " err_cnt"}, 64'(err_cnt), 64'(mErrCnt));
        checkOutput({tag, " data_err"}, 64'(data_err), 64'(mDataErr));
        checkOutput({tag, " prot_err"}, 64'(prot_err), 64'(mProtErr));
        checkOutput({tag, " bnd_err"}, 64'(bnd_err), 64'(mBndErr));
        checkOutput({tag, " len_err"}, 64'(len_err), 64'(mLenErr));
        checkOutput({tag, " first_err_addr"}, 64'(first_err_addr), 64'(mFirstErr));
        checkOutput({tag, " rd_finish pulses"}, 64'(finishCount), 64'(expFinish));
    endtask

    // Monitor: every AR handshake must match the oldest queued command; count rd_finish pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_finish) finishCount++;
            if (arvalid && arready) begin
                if (arQ.size() == 0) begin
                    timeoutFail("unexpected AR handshake");
                end else begin
                    ar_exp_t e;
                    e = arQ.pop_front();
                    checkOutput("araddr", 64'(araddr), 64'(e.addr));
                    checkOutput("arlen", 64'(arlen), 64'(e.len));
                    checkOutput("arid", 64'(arid), 64'(e.id));
                end
            end
        end
    end

    task automatic applyStimulus(input string tag, input logic [31:0] addr, input int len,
                                 input bit holdEn, input int arDelay, input int corruptBeat,
                                 input int corruptLane, input int badRespBeat,
                                 input int earlyLastBeat, input int abortBeat, input bit doCheck);
        int           effLen;
        int           n;
        logic [31:0]  word;
        logic [31:0]  junk;
        logic [511:0] beat;
        ar_exp_t      e;
        effLen = (len == 0) ? 1 : len;
        rd_addr = addr;
        rd_burst_length = 8'(len);
        rd_en = 1'b1;
        e.addr = addr;
        e.len  = 8'(effLen - 1);
        e.id   = 4'(mExpId);
        arQ.push_back(e);
        if (len == 0) mLenErr = 1;
        if ((addr % 4096) + effLen * 64 > 4096) mBndErr = 1;

        n = 0;
        while (!arvalid && n < 50) begin
            tick();
            n++;
        end
        if (!arvalid) begin
            timeoutFail({tag, " arvalid"});
            rd_en = 1'b0;
            return;
        end
        if (!holdEn) rd_en = 1'b0;

        for (int d = 0; d < arDelay; d++) begin
            junk = $urandom;
            rdata = {16{junk}};
            rvalid = 1'b1;
            if (d == 0) checkOutput({tag, " rready outside DATA"}, 64'(rready), 64'd0);
            tick();
        end
        rvalid = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;

        for (int i = 0; i < effLen; i++) begin
            rvalid = 1'b0;
            rlast = 1'b0;
            repeat ($urandom_range(0, 1)) tick();
            word = addr + 32'(i * 64);
            beat = {16{word}};
            if (i == corruptBeat) beat[corruptLane*32 +: 32] = word ^ 32'h00F0_0001;
            rdata  = beat;
            rid    = 4'(mExpId);
            rresp  = (i == badRespBeat) ? 2'd2 : 2'd0;
            rlast  = (i == effLen - 1) || (i == earlyLastBeat);
            rvalid = 1'b1;
            if (i == abortBeat) begin
                #2 reset = 1'b1;
                #1;
                checkOutput({tag, " abort arvalid"}, 64'(arvalid), 64'd0);
                checkOutput({tag, " abort rready"}, 64'(rready), 64'd0);
                checkOutput({tag, " abort rd_finish"}, 64'(rd_finish), 64'd0);
                checkOutput({tag, " abort beat_cnt"}, 64'(beat_cnt), 64'd0);
                checkOutput({tag, " abort araddr"}, 64'(araddr), 64'd0);
                rvalid = 1'b0;
                rlast = 1'b0;
                resetModel();
                mExpId = 0;
                tick();
                tick();
                reset = 1'b0;
                repeat (3) tick();
                checkOutput({tag, " abort no rd_finish"}, 64'(finishCount), 64'(expFinish));
                return;
            end
            n = 0;
            while (!rready && n < 20) begin
                tick();
                n++;
            end
            if (!rready) begin
                timeoutFail({tag, " rready"});
                rvalid = 1'b0;
                return;
            end
            tick();
            mBeatCnt++;
            if (i == corruptBeat) begin
                mErrCnt++;
                if (!mDataErr) mFirstErr = word;
                mDataErr = 1;
            end
            if (i == badRespBeat || i == earlyLastBeat) mProtErr = 1;
        end
        rvalid = 1'b0;
        rlast = 1'b0;

        n = 0;
        while (!rd_finish && n < 50) begin
            tick();
            n++;
        end
        if (!rd_finish) begin
            timeoutFail({tag, " rd_finish"});
            return;
        end
        expFinish++;
        mExpId = (mExpId + 1) % 16;
        if (doCheck) begin
            tick();
            checkStatus(tag);
        end
    endtask

    task automatic pulseClear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        resetModel();
        checkStatus("after clr");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          len;
        int          cb;
        int          br;
        logic [31:0] addr;
        reset = 1'b1;
        rd_en = 1'b0;
        rd_addr = 32'h0;
        rd_burst_length = 8'd0;
        arready = 1'b0;
        rdata = '0;
        rid = 4'd0;
        rresp = 2'd0;
        rlast = 1'b0;
        rvalid = 1'b0;
        clr = 1'b0;
        resetModel();
        mExpId = 0;
        repeat (3) tick();
        checkOutput("reset arvalid", 64'(arvalid), 64'd0);
        checkOutput("reset rready", 64'(rready), 64'd0);
        checkStatus("reset");
        reset = 1'b0;
        tick();

        applyStimulus("single20", 32'h0000_0000, 20, 0, 3, -1, 0, -1, -1, -1, 1);
        applyStimulus("bnd", 32'h0000_0F00, 8, 0, 1, -1, 0, -1, -1, -1, 1);
        applyStimulus("corrupt", 32'h0001_0000, 16, 0, 2, 5, 3, -1, -1, -1, 1);
        applyStimulus("prot", 32'h0002_0000, 4, 0, 0, -1, 0, 0, 2, -1, 1);
        applyStimulus("abort", 32'h0003_0000, 10, 0, 1, -1, 0, -1, -1, 3, 0);

        applyStimulus("b2b0", 32'h0004_0000, 3, 1, 0, -1, 0, -1, -1, -1, 0);
        applyStimulus("b2b1", 32'h0004_1000, 5, 1, 1, -1, 0, -1, -1, -1, 0);
        applyStimulus("b2b2", 32'h0004_2000, 2, 1, 0, -1, 0, -1, -1, -1, 0);
        applyStimulus("b2b3", 32'h0004_3000, 4, 0, 2, -1, 0, -1, -1, -1, 1);

        applyStimulus("len0", 32'h0005_0000, 0, 0, 1, -1, 0, -1, -1, -1, 1);
        pulseClear();

        for (int k = 0; k < 8; k++) begin
            addr = $urandom & 32'hFFFF_FFC0;
            len  = $urandom_range(1, 24);
            cb   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            br   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            applyStimulus($sformatf("rand%0d", k), addr, len, 0, $urandom_range(0, 4),
                          cb, $urandom_range(0, 15), br, -1, -1, 1);
        end

        checkOutput("AR queue drained", 64'(arQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
